// File: rtl/tmds_hdmi_encoder.sv
// Three-channel TMDS encoder with HDMI video preamble / guard-band insertion.
// A look-ahead delay line lets the control FSM see active video before it reaches the output.

module tmds_chan_enc #(
   parameter int C_dc_bal = 1
) (
   input  logic        [7:0] d,
   input  logic signed [4:0] disp,
   output logic        [9:0] q,
   output logic signed [4:0] disp_nxt
);
   logic        [3:0] n1d;
   logic        [3:0] n1q;
   logic              use_xnor;
   logic        [8:0] qm;
   logic signed [4:0] bal;

   always_comb begin
      n1d = '0;
      for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, d[i]};
      use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !d[0]);
      qm    = '0;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~use_xnor;
      n1q = '0;
      for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, qm[i]};
      // ones minus zeros of q_m[7:0]; wraps harmlessly since the result is in -8..8
      bal = $signed({n1q, 1'b0}) - 5'sd8;

      q        = {1'b0, qm};
      disp_nxt = 5'sd0;
      if (C_dc_bal != 0) begin
         if (disp == 5'sd0 || bal == 5'sd0) begin
            q        = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            disp_nxt = qm[8] ? disp + bal : disp - bal;
         end else if ((disp > 5'sd0 && bal > 5'sd0) || (disp < 5'sd0 && bal < 5'sd0)) begin
            q        = {1'b1, qm[8], ~qm[7:0]};
            disp_nxt = disp - bal + (qm[8] ? 5'sd2 : 5'sd0);
         end else begin
            q        = {1'b0, qm};
            disp_nxt = disp + bal - (qm[8] ? 5'sd0 : 5'sd2);
         end
      end
   end
endmodule

module tmds_hdmi_encoder #(
   parameter int C_depth   = 8,
   parameter int C_hdmi    = 1,
   parameter int C_pre_len = 8,
   parameter int C_gb_len  = 2,
   parameter int C_dc_bal  = 1
) (
   input  logic               clk_pixel,
   input  logic               rst_n,
   input  logic [C_depth-1:0] in_red,
   input  logic [C_depth-1:0] in_green,
   input  logic [C_depth-1:0] in_blue,
   input  logic               in_blank,
   input  logic               in_hsync,
   input  logic               in_vsync,
   output logic [9:0]         out_red,
   output logic [9:0]         out_green,
   output logic [9:0]         out_blue,
   output logic               out_de,
   output logic               err_short_blank
);
   localparam int         L        = C_pre_len + C_gb_len;
   localparam logic [3:0] PRE_LAST = 4'(C_pre_len - 1);
   localparam logic [3:0] GB_LAST  = 4'(C_gb_len - 1);
   localparam logic [9:0] CTL00    = 10'b1101010100;
   localparam logic [9:0] CTL01    = 10'b0010101011;
   localparam logic [9:0] GB_BR    = 10'b1011001100;
   localparam logic [9:0] GB_G     = 10'b0100110011;

   typedef struct packed {
      logic [2:0][7:0] rgb;
      logic            blank;
      logic            hs;
      logic            vs;
   } smp_t;
   localparam smp_t RST_SMP = '{rgb: '0, blank: 1'b1, hs: 1'b0, vs: 1'b0};

   typedef enum logic [1:0] {CTRL, PREAMBLE, GUARD, VIDEO} state_t;

   smp_t                   in_s, tail;
   smp_t                   dl [L];
   logic [2:0][C_depth-1:0] raw;
   logic [2:0][9:0]        vq;
   logic signed [4:0]      disp [3];
   logic signed [4:0]      disp_nxt [3];
   state_t                 state;
   logic [3:0]             cnt;
   logic                   blank_q;

   function automatic logic [9:0] ctl(input logic [1:0] c);
      case (c)
         2'b00:   return CTL00;
         2'b01:   return CTL01;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   assign raw = {in_red, in_green, in_blue};

   // Narrow samples are widened by repeating their MSB-first pattern into the LSBs
   always_comb begin
      in_s       = RST_SMP;
      in_s.blank = in_blank;
      in_s.hs    = in_hsync;
      in_s.vs    = in_vsync;
      for (int c = 0; c < 3; c++)
         for (int i = 0; i < 8; i++)
            in_s.rgb[c][7-i] = raw[c][C_depth-1 - (i % C_depth)];
   end

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < L; k++) dl[k] <= RST_SMP;
      end else begin
         dl[0] <= in_s;
         for (int k = 1; k < L; k++) dl[k] <= dl[k-1];
      end
   end

   assign tail = dl[L-1];

   for (genvar c = 0; c < 3; c++) begin : g_ch
      tmds_chan_enc #(.C_dc_bal(C_dc_bal)) u_enc (
         .d        (tail.rgb[c]),
         .disp     (disp[c]),
         .q        (vq[c]),
         .disp_nxt (disp_nxt[c])
      );
   end

   // Outputs are registered alongside the next state, so a word lands on the
   // output the cycle after its tail sample is examined.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         state           <= CTRL;
         cnt             <= '0;
         blank_q         <= 1'b1;
         out_red         <= CTL00;
         out_green       <= CTL00;
         out_blue        <= CTL00;
         out_de          <= 1'b0;
         err_short_blank <= 1'b0;
         for (int c = 0; c < 3; c++) disp[c] <= '0;
      end else begin
         blank_q         <= in_blank;
         out_blue        <= ctl({tail.vs, tail.hs});
         out_green       <= CTL00;
         out_red         <= CTL00;
         out_de          <= 1'b0;
         err_short_blank <= 1'b0;
         for (int c = 0; c < 3; c++) disp[c] <= '0;
         case (state)
            CTRL:
               if (C_hdmi != 0 && !in_blank && blank_q) begin
                  state     <= PREAMBLE;
                  cnt       <= '0;
                  out_green <= CTL01;
               end
            PREAMBLE:
               if (cnt == PRE_LAST) begin
                  state     <= GUARD;
                  cnt       <= '0;
                  out_blue  <= GB_BR;
                  out_green <= GB_G;
                  out_red   <= GB_BR;
               end else begin
                  cnt       <= cnt + 4'd1;
                  out_green <= CTL01;
               end
            GUARD:
               if (cnt == GB_LAST) begin
                  state <= CTRL;
               end else begin
                  cnt       <= cnt + 4'd1;
                  out_blue  <= GB_BR;
                  out_green <= GB_G;
                  out_red   <= GB_BR;
               end
            default: state <= CTRL;
         endcase
         // Active video at the tail always wins; anything but a completed guard band is a short blank
         if (!tail.blank) begin
            state           <= VIDEO;
            out_de          <= 1'b1;
            out_red         <= vq[2];
            out_green       <= vq[1];
            out_blue        <= vq[0];
            for (int c = 0; c < 3; c++) disp[c] <= disp_nxt[c];
            err_short_blank <= (C_hdmi != 0) && (state != VIDEO) &&
                               !(state == GUARD && cnt == GB_LAST);
         end
      end
   end
endmodule

// File: tb/tb_tmds_hdmi_encoder.sv
// Directed bench: HDMI, DVI and 5-bit-depth encoders driven by a shared vector table
// plus hand-written sequences for data pattern, mid-frame reset and short blank.

module tb_tmds_hdmi_encoder;
   localparam logic [9:0] C00 = 10'b1101010100;
   localparam logic [9:0] C01 = 10'b0010101011;
   localparam logic [9:0] C10 = 10'b0101010100;
   localparam logic [9:0] C11 = 10'b1010101011;
   localparam logic [9:0] GBR = 10'b1011001100;
   localparam logic [9:0] GBG = 10'b0100110011;
   localparam logic [9:0] WA  = 10'b0100000000;
   localparam logic [9:0] WB  = 10'b1111111111;
   localparam logic [9:0] W10 = 10'b0111110000;
   localparam logic [9:0] W5G = 10'b1011000110;
   localparam int NV = 76;

   typedef struct packed {
      logic        blank, hs, vs;
      logic [7:0]  r;
      logic [31:0] exp_h, exp_d;
   } vec_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic blank = 1'b1, hs = 1'b0, vs = 1'b0;
   logic [7:0] r = '0, g = '0, b = '0;
   logic [4:0] r5 = '0, g5 = 5'b10110, b5 = '0;
   logic [9:0] h_r, h_g, h_b, d_r, d_g, d_b, f_r, f_g, f_b;
   logic h_de, h_err, d_de, d_err, f_de, f_err;
   logic [31:0] h_pk, d_pk, f_pk;

   int checks = 0, failures = 0;
   vec_t tbl [NV];
   logic [7:0] pv [3] = '{8'h00, 8'hFF, 8'h55};
   logic [9:0] w6 [6] = '{WA, 10'b0011111111, 10'b0100110011, WB, 10'b1000000000, 10'b0100110011};
   logic [9:0] w, bctl;
   logic [31:0] ctrl;
   int cdisp, maxabs, j;
   int rd [3];
   int de_h, de_d, err_h, err_d, err_tick;

   always #5 clk = ~clk;

   tmds_hdmi_encoder u_hdmi (
      .clk_pixel(clk), .rst_n(rst_n), .in_red(r), .in_green(g), .in_blue(b),
      .in_blank(blank), .in_hsync(hs), .in_vsync(vs),
      .out_red(h_r), .out_green(h_g), .out_blue(h_b), .out_de(h_de), .err_short_blank(h_err));

   tmds_hdmi_encoder #(.C_hdmi(0)) u_dvi (
      .clk_pixel(clk), .rst_n(rst_n), .in_red(r), .in_green(g), .in_blue(b),
      .in_blank(blank), .in_hsync(hs), .in_vsync(vs),
      .out_red(d_r), .out_green(d_g), .out_blue(d_b), .out_de(d_de), .err_short_blank(d_err));

   tmds_hdmi_encoder #(.C_depth(5)) u_d5 (
      .clk_pixel(clk), .rst_n(rst_n), .in_red(r5), .in_green(g5), .in_blue(b5),
      .in_blank(blank), .in_hsync(hs), .in_vsync(vs),
      .out_red(f_r), .out_green(f_g), .out_blue(f_b), .out_de(f_de), .err_short_blank(f_err));

   assign h_pk = {h_r, h_g, h_b, h_de, h_err};
   assign d_pk = {d_r, d_g, d_b, d_de, d_err};
   assign f_pk = {f_r, f_g, f_b, f_de, f_err};

   function automatic logic [9:0] ctl(input logic v, input logic h);
      case ({v, h})
         2'b00:   return C00;
         2'b01:   return C01;
         2'b10:   return C10;
         default: return C11;
      endcase
   endfunction

   // Reference DVI 1.0 encoder written from the flowchart, disparity as a plain int
   task automatic golden(input logic [7:0] d, input int cin, output logic [9:0] q, output int cout);
      int n1, n1q, n0q;
      logic xn;
      logic [8:0] qm;
      n1 = $countones(d);
      xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (cin == 0 || n1q == n0q) begin
         q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         cout = qm[8] ? cin + (n1q - n0q) : cin + (n0q - n1q);
      end else if ((cin > 0 && n1q > n0q) || (cin < 0 && n0q > n1q)) begin
         q = {1'b1, qm[8], ~qm[7:0]};
         cout = cin + 2 * int'(qm[8]) + (n0q - n1q);
      end else begin
         q = {1'b0, qm[8], qm[7:0]};
         cout = cin - 2 * (qm[8] ? 0 : 1) + (n1q - n0q);
      end
   endtask

   task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s idx=%0d got=%h exp=%h", nm, idx, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic bl, input logic [7:0] v);
      blank = bl; hs = 1'b0; vs = 1'b0; r = v; g = v; b = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      // stimulus: blank 0..39 (vs 10..14, hs 20..29), active red=0x10 40..55, blank 56..75
      for (int i = 0; i < NV; i++) begin
         tbl[i].blank = !(i >= 40 && i < 56);
         tbl[i].hs    = (i >= 20 && i < 30);
         tbl[i].vs    = (i >= 10 && i < 15);
         tbl[i].r     = tbl[i].blank ? 8'h00 : 8'h10;
      end
      for (int i = 0; i < NV; i++) begin
         bctl = (i >= 10) ? ctl(tbl[i-10].vs, tbl[i-10].hs) : C00;
         ctrl = {C00, C00, bctl, 2'b00};
         if (i < 40 || i >= 66) begin
            tbl[i].exp_h = ctrl; tbl[i].exp_d = ctrl;
         end else if (i < 48) begin
            tbl[i].exp_h = {C00, C01, bctl, 2'b00}; tbl[i].exp_d = ctrl;
         end else if (i < 50) begin
            tbl[i].exp_h = {GBR, GBG, GBR, 2'b00}; tbl[i].exp_d = ctrl;
         end else begin
            // zero data walks disparity 0,-8,2,-6,4,-4,6,-2,8 then repeats every 9 words
            w = (((i - 50) % 9) % 2 == 0) ? WA : WB;
            tbl[i].exp_h = {W10, w, w, 2'b10}; tbl[i].exp_d = tbl[i].exp_h;
         end
      end

      set_in(1'b1, 8'h00);
      #12;
      check("reset_hdmi", 0, h_pk, {C00, C00, C00, 2'b00});
      check("reset_dvi",  0, d_pk, {C00, C00, C00, 2'b00});
      check("reset_d5",   0, f_pk, {C00, C00, C00, 2'b00});
      #5 rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         blank = tbl[i].blank; hs = tbl[i].hs; vs = tbl[i].vs;
         r = tbl[i].r; g = 8'h00; b = 8'h00;
         tick;
         check("tbl_hdmi", i, h_pk, tbl[i].exp_h);
         check("tbl_dvi",  i, d_pk, tbl[i].exp_d);
         if (tbl[i].exp_h[1]) check("depth5_green", i, {21'd0, f_g, f_de}, {21'd0, W5G, 1'b1});
      end

      // 0x00/0xFF/0x55 pattern against the reference encoder
      set_in(1'b1, 8'h00);
      repeat (40) tick;
      cdisp = 0; maxabs = 0; rd = '{0, 0, 0};
      for (int k = 1; k <= 55; k++) begin
         if (k <= 30) set_in(1'b0, pv[(k-1) % 3]);
         else set_in(1'b1, 8'h00);
         tick;
         if (k >= 11 && k <= 40) begin
            j = k - 11;
            golden(pv[j % 3], cdisp, w, cdisp);
            check("pattern", k, h_pk, {w, w, w, 2'b10});
            if (j < 6) check("pattern_hand", j, {22'd0, h_g}, {22'd0, w6[j]});
            rd[0] += 2 * $countones(h_r) - 10;
            rd[1] += 2 * $countones(h_g) - 10;
            rd[2] += 2 * $countones(h_b) - 10;
            for (int c = 0; c < 3; c++) begin
               if (rd[c] > maxabs) maxabs = rd[c];
               if (-rd[c] > maxabs) maxabs = -rd[c];
            end
         end else begin
            check("pattern_noact", k, {30'd0, h_de, h_err}, 32'd0);
         end
      end
      checks++;
      if (maxabs > 10) begin
         failures++;
         $display("FAIL disparity_bound got=%0d limit=10", maxabs);
      end

      // asynchronous reset in the middle of video, then delay line must come back empty
      set_in(1'b1, 8'h00);
      repeat (20) tick;
      for (int k = 1; k <= 15; k++) begin
         set_in(1'b0, 8'h55);
         tick;
      end
      check("pre_reset_de", 0, {31'd0, h_de}, 32'd1);
      set_in(1'b1, 8'h00);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_hdmi", 0, h_pk, {C00, C00, C00, 2'b00});
      check("async_reset_d5",   0, f_pk, {C00, C00, C00, 2'b00});
      tick;
      tick;
      #2 rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick;
         check("post_reset", k, h_pk, {C00, C00, C00, 2'b00});
      end

      // active 10 / blank 5 / active 10: second period arrives without preamble room
      repeat (20) tick;
      de_h = 0; de_d = 0; err_h = 0; err_d = 0; err_tick = -1;
      for (int k = 1; k <= 55; k++) begin
         if (k <= 10 || (k >= 16 && k <= 25)) set_in(1'b0, 8'h55);
         else set_in(1'b1, 8'h00);
         tick;
         de_h += int'(h_de); de_d += int'(d_de);
         err_d += int'(d_err);
         if (h_err) begin
            err_h++;
            err_tick = k;
            check("err_with_de", k, {31'd0, h_de}, 32'd1);
         end
      end
      check("short_de_count_hdmi", 0, de_h, 32'd20);
      check("short_de_count_dvi",  0, de_d, 32'd20);
      check("short_err_count",     0, err_h, 32'd1);
      check("short_err_tick",      0, err_tick, 32'd26);
      check("dvi_err_count",       0, err_d, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
